lfsr_range_rng: RTL and testbench
=================================

Name: lfsr_range_rng

Overview:
- Parametrised pseudo-random source for the augmentation pipeline (rotation, flip, crop-offset selection).
- Built around a Fibonacci XNOR LFSR of configurable width and tap mask, with run-time seed loading.
- Produces uniform values in [0, range_max] by rejection sampling, delivered one at a time over a valid/ready handshake.
- One instance per augmentation type; consumers draw a value, then apply it.

Parameters:
- LFSR_WIDTH, 16, LFSR state width in bits, legal range 4..32.
- TAPS, 16'hB400, feedback mask; bit i set means d[i] is included in the XNOR feedback.
- SEED, 16'hACE1, reset and fallback seed; must not be all-ones.
- OUT_WIDTH, 4, width of the output value; must be <= LFSR_WIDTH.
- MAX_REJECT, 8, consecutive rejections allowed before fallback, >= 1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, allows the LFSR to advance while generating.
- seed_load, input, 1, synchronous seed load strobe.
- seed_in, input, LFSR_WIDTH, seed value captured on seed_load.
- range_max, input, OUT_WIDTH, inclusive upper bound for output values.
- out_valid, output, 1, out_value is available.
- out_ready, input, 1, consumer accepts out_value.
- out_value, output, OUT_WIDTH, random value in [0, range_max].
- fallback, output, 1, high with out_valid when the value came from the rejection fallback.
- lockup, output, 1, one-cycle pulse when lockup recovery fires (optional feature).

Behaviour:
- Reset (async): d=SEED, state=GEN, rej_cnt=0, out_valid=0, out_value=0, fallback=0, lockup=0.
- Feedback: fb = ~^(d & TAPS). Next state = {fb, d[LFSR_WIDTH-1:1]}.
- All-ones is the lockup state. All-zeros is legal.
- Candidate: cand = d[OUT_WIDTH-1:0], taken from the current state before the shift.

State GEN (out_valid=0):
- Each cycle with enable=1, evaluate cand against range_max sampled in the same cycle, and advance the LFSR.
- If cand <= range_max: out_value<=cand, fallback<=0, rej_cnt<=0, out_valid<=1, go to HOLD.
- Else if rej_cnt == MAX_REJECT-1: out_value<=0, fallback<=1, rej_cnt<=0, out_valid<=1, go to HOLD.
- Else: rej_cnt++, stay in GEN.
- enable=0 freezes d, rej_cnt and state.

State HOLD (out_valid=1):
- d is frozen.
- out_value and fallback are stable regardless of range_max changes.
- When out_ready=1: out_valid<=0, go to GEN.

Throughput and latency:
- Best case is one value per 2 cycles.
- Latency from entering GEN to out_valid is 1 + (number of rejections) cycles.

seed_load:
- Highest synchronous priority, accepted in any state and independent of enable.
- Effects: d<=seed_in, or SEED if seed_in is all-ones; rej_cnt<=0; out_valid<=0; fallback<=0; state<=GEN.
- A pending out_value is discarded even if out_ready is high in the same cycle.

Simultaneous events:
- reset overrides all. seed_load overrides handshake and generation.
- out_ready while in GEN is ignored.

Reset mid-operation: out_valid drops asynchronously and the state returns to SEED.

Optional Feature:
- Macro LFSR_LOCKUP_RECOVER_EN.
- Defined: in GEN with enable=1, if d is all-ones (reachable only via upset or an illegal SEED), d<=all-zeros instead of shifting. No candidate is evaluated that cycle, and lockup pulses for one cycle.
- Undefined: no detection logic; lockup is tied to 0, and an all-ones state persists forever (every cycle re-evaluates the same candidate).

Test Plan:
- Reset release with LFSR_WIDTH=16, SEED=16'hACE1, range_max=15, enable=1, out_ready=0 -> out_valid=1 on 2nd clock, out_value=4'h1, fallback=0; holds stable for 10 cycles.
- seed_load with seed_in=16'h0000, range_max=15, out_ready=1 -> out_value=0 two cycles after seed_load. Next value is taken from d=16'h8000 and is 0.
- seed_in=16'hFFFF -> treated as SEED 16'hACE1; first out_value=4'h1.
- MAX_REJECT=1, seed_in=16'h000F, range_max=3 -> out_valid=1 two cycles after load, out_value=0, fallback=1.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release the sequence repeats the first scenario.
- With LFSR_LOCKUP_RECOVER_EN, SEED=16'hFFFF -> lockup pulses 1 cycle after reset release, then d=16'h0000, and the next out_value=0.

Source files
------------

// File: rtl/lfsr_range_rng_if.sv
// Output handshake bundle of the range-limited LFSR random source.
// master drives value/valid/fallback, slave returns ready.
interface lfsr_range_rng_if #(
  parameter int OUT_WIDTH = 4
);
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_value;
  logic                 fallback;

  modport master (
    output out_valid,
    output out_value,
    output fallback,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  fallback,
    output out_ready
  );
endinterface

// File: rtl/lfsr_range_rng.sv
// Fibonacci XNOR LFSR with rejection sampling into [0, range_max].
// Define LFSR_LOCKUP_RECOVER_EN to escape the all-ones lockup state.
module lfsr_range_rng #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter int                    OUT_WIDTH  = 4,
  parameter int                    MAX_REJECT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic [OUT_WIDTH-1:0]  range_max,
  lfsr_range_rng_if.master      out,
  output logic                  lockup
);

  localparam int RW = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
  localparam logic [LFSR_WIDTH-1:0] ONES = {LFSR_WIDTH{1'b1}};
  localparam logic [RW-1:0] REJ_LAST = RW'(MAX_REJECT - 1);

  typedef enum logic {
    GEN,
    HOLD
  } state_t;

  state_t                state_q, state_n;
  logic [LFSR_WIDTH-1:0] d_q, d_n;
  logic [RW-1:0]         rej_q, rej_n;
  logic                  valid_q, valid_n;
  logic [OUT_WIDTH-1:0]  value_q, value_n;
  logic                  fb_q, fb_n;
  logic                  lock_q, lock_n;

  logic [OUT_WIDTH-1:0]  cand;
  logic                  feedback;
  logic [LFSR_WIDTH-1:0] shifted;
  logic                  stuck;

  assign cand     = d_q[OUT_WIDTH-1:0];
  assign feedback = ~^(d_q & TAPS);
  assign shifted  = {feedback, d_q[LFSR_WIDTH-1:1]};

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign stuck = (d_q == ONES);
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GEN;
      d_q     <= SEED;
      rej_q   <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
      fb_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      d_q     <= d_n;
      rej_q   <= rej_n;
      valid_q <= valid_n;
      value_q <= value_n;
      fb_q    <= fb_n;
      lock_q  <= lock_n;
    end
  end

  always_comb begin
    state_n = state_q;
    d_n     = d_q;
    rej_n   = rej_q;
    valid_n = valid_q;
    value_n = value_q;
    fb_n    = fb_q;
    lock_n  = 1'b0;
    if (seed_load) begin
      // An all-ones seed would lock the XNOR LFSR, so use SEED instead
      d_n     = (seed_in == ONES) ? SEED : seed_in;
      rej_n   = '0;
      valid_n = 1'b0;
      fb_n    = 1'b0;
      state_n = GEN;
    end else begin
      unique case (state_q)
        GEN: begin
          if (enable) begin
            if (stuck) begin
              d_n    = '0;
              lock_n = 1'b1;
            end else begin
              d_n = shifted;
              if (cand <= range_max) begin
                value_n = cand;
                fb_n    = 1'b0;
                rej_n   = '0;
                valid_n = 1'b1;
                state_n = HOLD;
              end else if (rej_q == REJ_LAST) begin
                value_n = '0;
                fb_n    = 1'b1;
                rej_n   = '0;
                valid_n = 1'b1;
                state_n = HOLD;
              end else begin
                rej_n = rej_q + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out.out_ready) begin
            valid_n = 1'b0;
            fb_n    = 1'b0;
            state_n = GEN;
          end
        end
        default: state_n = GEN;
      endcase
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_value = value_q;
  assign out.fallback  = fb_q;
  assign lockup        = lock_q;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Randomized bench for lfsr_range_rng against a transaction-level draw model.
// Summary line: CHECKS <n> ERRORS <n>.
module tb_lfsr_range_rng;

  localparam int W    = 16;
  localparam int OW   = 4;
  localparam int MAXR = 8;
  localparam logic [W-1:0] TAPS = 16'hB400;
  localparam logic [W-1:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          seed_load;
  logic [W-1:0]  seed_in;
  logic [OW-1:0] range_max;
  logic          lockup;

  lfsr_range_rng_if #(.OUT_WIDTH(OW)) bus ();

  lfsr_range_rng #(
    .LFSR_WIDTH(W),
    .TAPS      (TAPS),
    .SEED      (SEED),
    .OUT_WIDTH (OW),
    .MAX_REJECT(MAXR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .range_max(range_max),
    .out      (bus.master),
    .lockup   (lockup)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] md;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One shift of the XNOR LFSR, from the parity of the tapped bits
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    int ones;
    logic [W-1:0] r;
    ones = $countones(s & TAPS);
    r = s >> 1;
    if (ones % 2 == 0) r = r | (16'h1 << (W - 1));
    return r;
  endfunction

  // Draw one value: up to MAXR candidates, then fall back to 0
  task automatic draw(inout logic [W-1:0] s, input int rmax,
                      output int v, output int f, output int n);
    bit done;
    int c;
    done = 0;
    v = 0;
    f = 0;
    n = 0;
    for (int r = 0; r < MAXR; r++) begin
      if (!done) begin
        c = s % (1 << OW);
        s = lfsr_next(s);
        n++;
        if (c <= rmax) begin
          v = c;
          done = 1;
        end else if (r == MAXR - 1) begin
          f = 1;
          done = 1;
        end
      end
    end
  endtask

  // Run one draw with the DUT in GEN; optionally jitter enable
  task automatic run_draw(input string tag, input int rmax, input bit jit,
                          input int hold);
    int v, f, n, k, cyc;
    draw(md, rmax, v, f, n);
    range_max = rmax[OW-1:0];
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      enable = jit ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cyc++;
      if (enable) k++;
      if (k < n) chk({tag, "_idle"}, bus.out_valid, 0);
    end
    enable = 1'b1;
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_value"}, bus.out_value, v);
    chk({tag, "_fallback"}, bus.fallback, f);
    for (int h = 0; h < hold; h++) begin
      range_max = OW'($urandom);
      enable = $urandom_range(0, 1);
      tick();
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_value"}, bus.out_value, v);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    enable = 1'b1;
    chk({tag, "_accept"}, bus.out_valid, 0);
    chk({tag, "_lockup"}, lockup, 0);
  endtask

  task automatic load(input logic [W-1:0] s, input bit rdy);
    seed_load = 1'b1;
    seed_in = s;
    bus.out_ready = rdy;
    tick();
    seed_load = 1'b0;
    bus.out_ready = 1'b0;
    chk("load_valid", bus.out_valid, 0);
    md = (s == 16'hFFFF) ? SEED : s;
  endtask

  initial begin
    int rm;
    reset = 1'b1;
    enable = 1'b1;
    seed_load = 1'b0;
    seed_in = '0;
    range_max = 4'hF;
    bus.out_ready = 1'b0;
    md = SEED;
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_value", bus.out_value, 0);
    chk("rst_fallback", bus.fallback, 0);
    chk("rst_lockup", lockup, 0);
    reset = 1'b0;

    run_draw("first", 15, 0, 10);

    // Asynchronous reset while a value is pending
    range_max = 4'hF;
    tick();
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    tick();
    reset = 1'b0;
    md = SEED;
    run_draw("after_rst", 15, 0, 2);

    load(16'h0000, 1'b0);
    run_draw("zero_a", 15, 0, 1);
    run_draw("zero_b", 15, 0, 1);

    load(16'hFFFF, 1'b0);
    run_draw("ones_seed", 15, 0, 1);

    load(16'h000F, 1'b0);
    run_draw("reject", 3, 0, 1);

    load(16'h1234, 1'b0);
    run_draw("range0", 0, 0, 1);

    // Load while a value is pending with ready high: value is discarded
    range_max = 4'hF;
    tick();
    chk("pend_valid", bus.out_valid, 1);
    load(16'h5A5A, 1'b1);
    run_draw("discard", 7, 0, 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        load(W'($urandom), $urandom_range(0, 1));
      rm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      run_draw("rand", rm, 1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
